// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: channel mode encoding.
package led_pattern_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        OFF     = 2'd0,
        ON      = 2'd1,
        BLINK   = 2'd2,
        ONESHOT = 2'd3
    } mode_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode FSM, half-period counter, registered LED drive and
// a one-cycle toggle strobe aligned with the LED output.
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int CNT_W        = 27,
    parameter int DEFAULT_HALF = 100_000_000
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              load,
    input  logic [MODE_W-1:0] load_mode,
    input  logic [CNT_W-1:0]  load_half,
    output logic              led,
    output logic              toggle_pulse
);

    mode_e            mode, mode_nxt;
    logic [CNT_W-1:0] half, half_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             led_int, led_int_nxt;
    logic             tc;

    assign tc = (cnt == half - CNT_W'(1));

    always_ff @(posedge clk100) begin
        if (rst) begin
            mode         <= BLINK;
            half         <= CNT_W'(DEFAULT_HALF);
            cnt          <= '0;
            led_int      <= 1'b0;
            led          <= 1'b0;
            toggle_pulse <= 1'b0;
        end else begin
            mode         <= mode_nxt;
            half         <= half_nxt;
            cnt          <= cnt_nxt;
            led_int      <= led_int_nxt;
            led          <= led_int;
            toggle_pulse <= led_int ^ led;
        end
    end

    // A zero half-period would never reach terminal count; treat it as 1.
    always_comb begin
        mode_nxt = mode;
        half_nxt = half;
        if (load) begin
            mode_nxt = mode_e'(load_mode);
            half_nxt = (load_half == '0) ? CNT_W'(1) : load_half;
        end else if (mode == ONESHOT && tc) begin
            mode_nxt = OFF;
        end
    end

    always_comb begin
        cnt_nxt     = '0;
        led_int_nxt = led_int;
        if (load) begin
            led_int_nxt = (mode_e'(load_mode) != OFF);
        end else begin
            case (mode)
                OFF: led_int_nxt = 1'b0;
                ON:  led_int_nxt = 1'b1;
                BLINK: begin
                    if (tc) led_int_nxt = ~led_int;
                    else    cnt_nxt     = cnt + CNT_W'(1);
                end
                ONESHOT: begin
                    if (tc) begin
                        led_int_nxt = 1'b0;
                    end else begin
                        led_int_nxt = 1'b1;
                        cnt_nxt     = cnt + CNT_W'(1);
                    end
                end
                default: led_int_nxt = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: config decode, out-of-range error
// strobe, and an array of independent channel engines.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 27,
    parameter int DEFAULT_HALF = 100_000_000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] toggle_pulse
);

    logic accept;
    logic in_range;

    assign cfg_ready = ~rst;
    assign accept    = cfg_valid & cfg_ready;
    assign in_range  = (32'(cfg_ch) < 32'(NUM_CH));

    // Out-of-range channels are still accepted; they only raise the strobe.
    always_ff @(posedge clk100) begin
        if (rst) cfg_err <= 1'b0;
        else     cfg_err <= accept & ~in_range;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk100       (clk100),
            .rst          (rst),
            .load         (accept && (cfg_ch == CH_W'(i))),
            .load_mode    (cfg_mode),
            .load_half    (cfg_half),
            .led          (led[i]),
            .toggle_pulse (toggle_pulse[i])
        );
    end

endmodule
